// File: rtl/gayle_sector_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : gayle_sector_seq_if                                           |
// | Purpose  : Bundle of command, strobe and status signals between the      |
// |            Gayle IDE host/firmware side and the sector sequencer.        |
// | Modports : master - drives commands/strobes, observes status             |
// |            slave  - the sequencer itself                                 |
// | Signals  : clk7_en, cmd_start, cmd_write, cmd_count[7:0], abort,         |
// |            host_rd, host_wr, fw_rd, fw_wr (master -> slave)              |
// |            fifo_rd, fifo_wr, bsy, drq, irq, fw_req, sectors_left[8:0],   |
// |            timeout_err (slave -> master)                                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface gayle_sector_seq_if;
  logic       clk7_en;
  logic       cmd_start;
  logic       cmd_write;
  logic [7:0] cmd_count;
  logic       abort;
  logic       host_rd;
  logic       host_wr;
  logic       fw_rd;
  logic       fw_wr;
  logic       fifo_rd;
  logic       fifo_wr;
  logic       bsy;
  logic       drq;
  logic       irq;
  logic       fw_req;
  logic [8:0] sectors_left;
  logic       timeout_err;

  modport master (
    output clk7_en, cmd_start, cmd_write, cmd_count, abort,
           host_rd, host_wr, fw_rd, fw_wr,
    input  fifo_rd, fifo_wr, bsy, drq, irq, fw_req, sectors_left, timeout_err
  );

  modport slave (
    input  clk7_en, cmd_start, cmd_write, cmd_count, abort,
           host_rd, host_wr, fw_rd, fw_wr,
    output fifo_rd, fifo_wr, bsy, drq, irq, fw_req, sectors_left, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/gayle_sector_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : gayle_sector_seq                                              |
// | Purpose  : Sector transfer sequencer for the Gayle IDE data path. Turns  |
// |            READ/WRITE SECTOR commands into per-sector firmware and host  |
// |            phases, gates data strobes into FIFO rd/wr, counts 256-word   |
// |            sectors and drives BSY/DRQ/IRQ and the firmware request.      |
// | Options  : GAYLE_SEQ_TIMEOUT_EN - enables the firmware-phase watchdog;   |
// |            otherwise timeout_err = 0.                                    |
// | Revision : 1.1 - flat port list                                          |
// +--------------------------------------------------------------------------+
module gayle_sector_seq #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd1000000
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    input  wire logic       clk7_en,
    input  wire logic       cmd_start,
    input  wire logic       cmd_write,
    input  wire logic [7:0] cmd_count,
    input  wire logic       abort,
    input  wire logic       host_rd,
    input  wire logic       host_wr,
    input  wire logic       fw_rd,
    input  wire logic       fw_wr,
    output logic            fifo_rd,
    output logic            fifo_wr,
    output logic            bsy,
    output logic            drq,
    output logic            irq,
    output logic            fw_req,
    output logic [8:0]      sectors_left,
    output logic            timeout_err
);

    localparam logic [2:0] c_ST_IDLE       = 3'd0;
    localparam logic [2:0] c_ST_FW_FILL    = 3'd1;
    localparam logic [2:0] c_ST_HOST_DRAIN = 3'd2;
    localparam logic [2:0] c_ST_HOST_FILL  = 3'd3;
    localparam logic [2:0] c_ST_FW_DRAIN   = 3'd4;

    logic [2:0] r_state;
    logic [2:0] w_state_d;
    logic [7:0] r_word;
    logic [7:0] w_word_d;
    logic [8:0] r_left;
    logic [8:0] w_left_d;
    logic       r_irq;
    logic       w_irq_d;
    logic       r_bsy;
    logic       r_drq;
    logic       r_fw_req;

    logic       w_acc_fw;
    logic       w_acc_host;
    logic       w_word_last;

`ifdef GAYLE_SEQ_TIMEOUT_EN
    logic [31:0] r_tmo;
    logic [31:0] w_tmo_d;
    logic        r_terr;
    logic        w_terr_d;
    logic        w_tmo_hit;
`endif

    always_comb begin
        w_acc_fw   = 1'b0;
        w_acc_host = 1'b0;
        if (clk7_en) begin
            case (r_state)
                c_ST_FW_FILL:    w_acc_fw   = fw_wr;
                c_ST_FW_DRAIN:   w_acc_fw   = fw_rd;
                c_ST_HOST_DRAIN: w_acc_host = host_rd;
                c_ST_HOST_FILL:  w_acc_host = host_wr;
                default:         ;
            endcase
        end
    end

    assign w_word_last = (w_acc_fw | w_acc_host) & (r_word == 8'hFF);

    assign fifo_wr = (w_acc_fw   & (r_state == c_ST_FW_FILL)) |
                     (w_acc_host & (r_state == c_ST_HOST_FILL));
    assign fifo_rd = (w_acc_host & (r_state == c_ST_HOST_DRAIN)) |
                     (w_acc_fw   & (r_state == c_ST_FW_DRAIN));

`ifdef GAYLE_SEQ_TIMEOUT_EN
    assign w_tmo_hit = ((r_state == c_ST_FW_FILL) || (r_state == c_ST_FW_DRAIN)) &&
                       !w_acc_fw && (r_tmo == 32'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        w_state_d = r_state;
        w_word_d  = r_word;
        w_left_d  = r_left;
        w_irq_d   = 1'b0;
`ifdef GAYLE_SEQ_TIMEOUT_EN
        w_terr_d  = r_terr;
        w_tmo_d   = 32'd0;
`endif
        if (abort) begin
            w_state_d = c_ST_IDLE;
            w_word_d  = 8'd0;
            w_left_d  = 9'd0;
`ifdef GAYLE_SEQ_TIMEOUT_EN
            w_terr_d  = 1'b0;
`endif
        end else begin
            if (w_acc_fw | w_acc_host) w_word_d = r_word + 8'd1;
            case (r_state)
                c_ST_IDLE: begin
                    if (cmd_start) begin
                        w_left_d  = (cmd_count == 8'd0) ? 9'd256 : {1'b0, cmd_count};
                        w_word_d  = 8'd0;
                        w_state_d = cmd_write ? c_ST_HOST_FILL : c_ST_FW_FILL;
`ifdef GAYLE_SEQ_TIMEOUT_EN
                        w_terr_d  = 1'b0;
`endif
                    end
                end
                c_ST_FW_FILL: begin
                    if (w_word_last) begin
                        w_state_d = c_ST_HOST_DRAIN;
                        w_irq_d   = 1'b1;
                    end
                end
                c_ST_HOST_DRAIN: begin
                    if (w_word_last) begin
                        w_left_d  = r_left - 9'd1;
                        w_state_d = (r_left == 9'd1) ? c_ST_IDLE : c_ST_FW_FILL;
                    end
                end
                c_ST_HOST_FILL: begin
                    if (w_word_last) w_state_d = c_ST_FW_DRAIN;
                end
                c_ST_FW_DRAIN: begin
                    if (w_word_last) begin
                        w_left_d  = r_left - 9'd1;
                        w_irq_d   = 1'b1;
                        w_state_d = (r_left == 9'd1) ? c_ST_IDLE : c_ST_HOST_FILL;
                    end
                end
                default: w_state_d = c_ST_IDLE;
            endcase
`ifdef GAYLE_SEQ_TIMEOUT_EN
            if (w_tmo_hit) begin
                w_state_d = c_ST_IDLE;
                w_word_d  = 8'd0;
                w_left_d  = 9'd0;
                w_terr_d  = 1'b1;
                w_irq_d   = 1'b1;
            end else if (((r_state == c_ST_FW_FILL) || (r_state == c_ST_FW_DRAIN)) && !w_acc_fw) begin
                w_tmo_d = r_tmo + 32'd1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= c_ST_IDLE;
            r_word   <= 8'd0;
            r_left   <= 9'd0;
            r_irq    <= 1'b0;
            r_bsy    <= 1'b0;
            r_drq    <= 1'b0;
            r_fw_req <= 1'b0;
`ifdef GAYLE_SEQ_TIMEOUT_EN
            r_tmo    <= 32'd0;
            r_terr   <= 1'b0;
`endif
        end else if (clk7_en) begin
            r_state  <= w_state_d;
            r_word   <= w_word_d;
            r_left   <= w_left_d;
            r_irq    <= w_irq_d;
            r_bsy    <= (w_state_d == c_ST_FW_FILL) || (w_state_d == c_ST_FW_DRAIN);
            r_fw_req <= (w_state_d == c_ST_FW_FILL) || (w_state_d == c_ST_FW_DRAIN);
            r_drq    <= (w_state_d == c_ST_HOST_DRAIN) || (w_state_d == c_ST_HOST_FILL);
`ifdef GAYLE_SEQ_TIMEOUT_EN
            r_tmo    <= w_tmo_d;
            r_terr   <= w_terr_d;
`endif
        end
    end

    assign bsy          = r_bsy;
    assign drq          = r_drq;
    assign fw_req       = r_fw_req;
    assign irq          = r_irq;
    assign sectors_left = r_left;
`ifdef GAYLE_SEQ_TIMEOUT_EN
    assign timeout_err  = r_terr;
`else
    assign timeout_err  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gayle_sector_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_gayle_sector_seq                                           |
// | Purpose  : Self-checking bench for gayle_sector_seq: command table,      |
// |            directed multi-sector sequences and randomized traffic        |
// |            against a word-position reference model.                      |
// | Revision : 1.1 - flat port connection                                    |
// +--------------------------------------------------------------------------+
module tb_gayle_sector_seq;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    gayle_sector_seq_if bus();

    gayle_sector_seq #(.TIMEOUT_CYCLES(50)) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clk7_en      (bus.clk7_en),
        .cmd_start    (bus.cmd_start),
        .cmd_write    (bus.cmd_write),
        .cmd_count    (bus.cmd_count),
        .abort        (bus.abort),
        .host_rd      (bus.host_rd),
        .host_wr      (bus.host_wr),
        .fw_rd        (bus.fw_rd),
        .fw_wr        (bus.fw_wr),
        .fifo_rd      (bus.fifo_rd),
        .fifo_wr      (bus.fifo_wr),
        .bsy          (bus.bsy),
        .drq          (bus.drq),
        .irq          (bus.irq),
        .fw_req       (bus.fw_req),
        .sectors_left (bus.sectors_left),
        .timeout_err  (bus.timeout_err)
    );

    int n_checks = 0;
    int n_errors = 0;
    int fifo_rd_total = 0;

    bit m_active, m_write, m_irq;
    int m_total, m_pos;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit m_fw_phase();
        int o;
        o = m_pos % 512;
        return m_active && (m_write ? (o >= 256) : (o < 256));
    endfunction

    function automatic bit m_host_phase();
        return m_active && !m_fw_phase();
    endfunction

    function automatic int m_left();
        return m_active ? (m_total - m_pos / 512) : 0;
    endfunction

    task automatic m_reset();
        m_active = 0; m_write = 0; m_irq = 0; m_total = 0; m_pos = 0;
    endtask

    task automatic check_outs();
        chk("bsy",          bus.bsy,          m_fw_phase());
        chk("fw_req",       bus.fw_req,       m_fw_phase());
        chk("drq",          bus.drq,          m_host_phase());
        chk("irq",          bus.irq,          m_irq);
        chk("sectors_left", bus.sectors_left, m_left());
        chk("timeout_err",  bus.timeout_err,  0);
    endtask

    task automatic drive(input bit en, input bit cs, input bit cw, input logic [7:0] cc,
                         input bit ab, input bit hr, input bit hw, input bit fr, input bit fw);
        bus.clk7_en = en; bus.cmd_start = cs; bus.cmd_write = cw; bus.cmd_count = cc;
        bus.abort = ab; bus.host_rd = hr; bus.host_wr = hw; bus.fw_rd = fr; bus.fw_wr = fw;
    endtask

    task automatic tick(input bit en, input bit cs, input bit cw, input logic [7:0] cc,
                        input bit ab, input bit hr, input bit hw, input bit fr, input bit fw);
        bit acc_rd, acc_wr;
        drive(en, cs, cw, cc, ab, hr, hw, fr, fw);
        @(negedge clk);
        acc_rd = en && ((m_fw_phase() && m_write && fr) || (m_host_phase() && !m_write && hr));
        acc_wr = en && ((m_fw_phase() && !m_write && fw) || (m_host_phase() && m_write && hw));
        chk("fifo_rd", bus.fifo_rd, acc_rd);
        chk("fifo_wr", bus.fifo_wr, acc_wr);
        if (bus.fifo_rd) fifo_rd_total++;
        @(posedge clk); #1;
        if (en) begin
            m_irq = 0;
            if (ab) begin
                m_active = 0; m_pos = 0; m_total = 0;
            end else if (!m_active) begin
                if (cs) begin
                    m_active = 1; m_write = cw; m_pos = 0;
                    m_total  = (cc == 8'd0) ? 256 : int'(cc);
                end
            end else if (acc_rd || acc_wr) begin
                m_pos++;
                if (!m_write && (m_pos % 512 == 256)) m_irq = 1;
                if (m_write && (m_pos % 512 == 0)) m_irq = 1;
                if (m_pos == 512 * m_total) begin
                    m_active = 0; m_pos = 0; m_total = 0;
                end
            end
        end
        check_outs();
    endtask

    task automatic start(input bit cw, input logic [7:0] cc);
        tick(1, 1, cw, cc, 0, 0, 0, 0, 0);
    endtask
    task automatic do_abort();
        tick(1, 0, 0, 8'd0, 1, 0, 0, 0, 0);
    endtask
    task automatic strobes(input int n, input bit hr, input bit hw, input bit fr, input bit fw);
        for (int i = 0; i < n; i++) tick(1, 0, 0, 8'd0, 0, hr, hw, fr, fw);
    endtask

    typedef struct {
        bit         cw;
        logic [7:0] cc;
        bit         ab;
        logic [8:0] e_left;
        bit         e_bsy;
        bit         e_drq;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{1'b0, 8'd1,   1'b0, 9'd1,   1'b1, 1'b0};
        tbl[1] = '{1'b0, 8'd0,   1'b0, 9'd256, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 8'd0,   1'b0, 9'd256, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 8'd255, 1'b0, 9'd255, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 8'd128, 1'b0, 9'd128, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 8'd5,   1'b1, 9'd0,   1'b0, 1'b0};

        drive(0, 0, 0, 8'd0, 0, 0, 0, 0, 0);
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_bsy", bus.bsy, 0);
        chk("reset_drq", bus.drq, 0);
        chk("reset_irq", bus.irq, 0);
        chk("reset_fw_req", bus.fw_req, 0);
        chk("reset_left", bus.sectors_left, 0);
        @(negedge clk);
        reset_n = 1'b1;

        strobes(4, 1, 1, 1, 1);

        for (int i = 0; i < 6; i++) begin
            do_abort();
            tick(1, 1, tbl[i].cw, tbl[i].cc, tbl[i].ab, 0, 0, 0, 0);
            chk("tbl_left", bus.sectors_left, tbl[i].e_left);
            chk("tbl_bsy",  bus.bsy,          tbl[i].e_bsy);
            chk("tbl_drq",  bus.drq,          tbl[i].e_drq);
            chk("tbl_irq",  bus.irq,          0);
        end
        do_abort();

        fifo_rd_total = 0;
        start(0, 8'd2);
        chk("rd_fw_req", bus.fw_req, 1);
        strobes(256, 0, 0, 0, 1);
        chk("rd_irq", bus.irq, 1);
        chk("rd_drq", bus.drq, 1);
        strobes(256, 1, 0, 0, 0);
        chk("rd_bsy2", bus.bsy, 1);
        chk("rd_left1", bus.sectors_left, 1);
        strobes(256, 0, 0, 0, 1);
        strobes(256, 1, 0, 0, 0);
        chk("rd_done_bsy", bus.bsy, 0);
        chk("rd_done_drq", bus.drq, 0);
        chk("rd_done_left", bus.sectors_left, 0);
        chk("rd_fifo_rd_total", fifo_rd_total, 512);

        start(1, 8'd1);
        chk("wr_drq", bus.drq, 1);
        chk("wr_no_irq", bus.irq, 0);
        strobes(256, 0, 1, 0, 0);
        chk("wr_bsy", bus.bsy, 1);
        chk("wr_fw_req", bus.fw_req, 1);
        strobes(256, 0, 0, 1, 0);
        chk("wr_irq", bus.irq, 1);
        chk("wr_idle_bsy", bus.bsy, 0);
        chk("wr_left0", bus.sectors_left, 0);

        start(0, 8'd0);
        chk("c0_left", bus.sectors_left, 256);
        for (int s = 0; s < 10; s++) begin
            strobes(256, 0, 0, 0, 1);
            strobes(256, 1, 0, 0, 0);
        end
        chk("c0_left246", bus.sectors_left, 246);
        do_abort();

        start(0, 8'd1);
        strobes(10, 1, 0, 0, 0);
        strobes(255, 0, 0, 0, 1);
        chk("wp_still_fill", bus.drq, 0);
        strobes(1, 0, 0, 0, 1);
        chk("wp_drain", bus.drq, 1);
        strobes(10, 0, 0, 0, 1);
        strobes(255, 1, 0, 0, 0);
        chk("wp_still_drain", bus.drq, 1);
        strobes(1, 1, 0, 0, 0);
        chk("wp_done", bus.drq, 0);

        start(1, 8'd3);
        strobes(100, 0, 1, 0, 0);
        do_abort();
        chk("ab_drq", bus.drq, 0);
        chk("ab_irq", bus.irq, 0);
        chk("ab_bsy", bus.bsy, 0);
        chk("ab_left", bus.sectors_left, 0);

        start(0, 8'd2);
        strobes(40, 0, 0, 0, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_bsy", bus.bsy, 0);
        chk("arst_fw_req", bus.fw_req, 0);
        chk("arst_drq", bus.drq, 0);
        chk("arst_left", bus.sectors_left, 0);
        chk("arst_fifo_wr", bus.fifo_wr, 0);
        m_reset();
        @(negedge clk);
        reset_n = 1'b1;

`ifdef GAYLE_SEQ_TIMEOUT_EN
        start(0, 8'd1);
        strobes(49, 0, 0, 0, 0);
        chk("tmo_not_yet", bus.bsy, 1);
        drive(1, 0, 0, 8'd0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("tmo_bsy", bus.bsy, 0);
        chk("tmo_err", bus.timeout_err, 1);
        chk("tmo_irq", bus.irq, 1);
        do_abort();
`endif

        for (int i = 0; i < 20000; i++) begin
            logic [7:0] cc;
            cc = 8'($urandom_range(1, 3));
            tick(($urandom_range(0, 7) != 0), ($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                 cc, ($urandom_range(0, 2999) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
